reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Controller that sequences the SoC reset from the PLL lock indication and the debounced reset-button pulse. It guarantees a minimum reset hold time and a lock-stability window before releasing the SoC. It re-enters reset on PLL lock loss or a button request. It sits in the board top level between clockgen/debouncer outputs and the soc reset_in, on the slow clock domain.

Parameters:
LOCK_STABLE_CYCLES  8   consecutive cycles synchronized lock must be high before HOLD begins (>=1)
HOLD_CYCLES         16  cycles soc reset is held after lock is stable or after a button request (>=1)
CNT_WIDTH           derived: clog2(max(LOCK_STABLE_CYCLES, HOLD_CYCLES))+1, not overridden

Ports:
clk_in               input   1  slow system clock; everything is on its rising edge
reset_in             input   1  synchronous, active-high; sequencer reset
pll_locked_in        input   1  PLL locked, asynchronous to clk_in
button_req_in        input   1  one-cycle reset request from debouncer rising-edge output, already synchronous
soc_reset_out        output  1  active-high reset to the SoC
ready_out            output  1  high while the SoC is out of reset (state RUN)
state_out            output  2  current state: 0 WAIT_LOCK, 1 HOLD, 2 RUN (3 never occurs)
lock_loss_count_out  output  8  number of RUN->WAIT_LOCK lock-loss events, saturating at 255

Behaviour:
- Lock synchronizer: 2-flop chain on pll_locked_in, both flops cleared by reset_in. lock_sync is the second flop. Latency is 2 edges.
- Moore FSM. Outputs decode the state register: soc_reset_out = (state != RUN), ready_out = (state == RUN).
- reset_in high at an edge: state=WAIT_LOCK, lock_cnt=0, hold_cnt=0, sync flops=0, lock_loss_count=0. reset_in has priority over everything. During reset: soc_reset_out=1, ready_out=0, state_out=0, lock_loss_count_out=0.
- WAIT_LOCK:
  - lock_sync=0: lock_cnt<=0.
  - lock_sync=1 and lock_cnt==LOCK_STABLE_CYCLES-1: go to HOLD, hold_cnt<=0.
  - lock_sync=1 otherwise: lock_cnt++.
  - button_req_in is ignored.
- HOLD, in priority order:
  - lock_sync=0: go to WAIT_LOCK, lock_cnt<=0. Not counted as a lock loss.
  - button_req_in=1: hold_cnt<=0 and stay in HOLD. Repeated requests stretch the hold.
  - hold_cnt==HOLD_CYCLES-1: go to RUN.
  - Otherwise: hold_cnt++.
- RUN, in priority order:
  - lock_sync=0: go to WAIT_LOCK, lock_cnt<=0, lock_loss_count++ (saturates at 255).
  - button_req_in=1: go to HOLD, hold_cnt<=0.
  - Lock loss wins over a simultaneous button request.
- Timing with lock constant high: edge 1 is the first edge with reset_in low. soc_reset_out goes low after edge 2+LOCK_STABLE_CYCLES+HOLD_CYCLES, i.e. edge 26 with defaults.
- Button-initiated reset: soc_reset_out is high for exactly HOLD_CYCLES cycles, provided no further request and no lock loss.
- Lock glitch: a lock drop shorter than 1 cycle can be missed. Any sampled low restarts the full stability window.
- Counters never exceed their terminal values. No wrap-around is possible.
- Parameters < 1 are illegal. Flag them with an elaboration-time assertion.

Test Plan:
1. Power-up: reset_in high 5 cycles then low, pll_locked_in held 1. Required: soc_reset_out=1 through edge 25, 0 after edge 26. ready_out mirrors. state_out goes 0->1 after edge 10, 1->2 after edge 26.
2. Late lock: pll_locked_in=0 for 40 cycles after reset release, then 1. Required: state stays 0 throughout. RUN is reached exactly 2+8+16 edges after the first edge sampling lock high.
3. Unstable lock: lock high 5 cycles, low 1 cycle, high again. Required: lock_cnt restarts, no HOLD entry until 8 consecutive synced-high cycles.
4. Button in RUN: single-cycle button_req_in. Required: soc_reset_out high on the next cycle for exactly 16 cycles, then RUN. lock_loss_count_out unchanged. Second pulse at hold_cnt=10 extends the total to 27 cycles high.
5. Lock loss in RUN with simultaneous button: lock_sync drops while button_req_in=1. Required: state goes to WAIT_LOCK, lock_loss_count_out increments 0->1. Run 300 loss events: required saturation at 255.
6. reset_in mid-HOLD (hold_cnt=7): required state_out=0, counters and lock_loss_count_out cleared next cycle, full sequence restarts.

Source files
------------

// File: rtl/reset_sequencer.sv
// SoC reset sequencer: waits for a stable synchronized PLL lock, holds the SoC in
// reset for a minimum time, then releases it; lock loss or a button request re-enters reset.
module reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 8,
    parameter int HOLD_CYCLES        = 16
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       pll_locked_in,
    input  logic       button_req_in,
    output logic       soc_reset_out,
    output logic       ready_out,
    output logic [1:0] state_out,
    output logic [7:0] lock_loss_count_out
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_WIDTH  = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);

    generate
        if (LOCK_STABLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
            $error("reset_sequencer: LOCK_STABLE_CYCLES and HOLD_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [CNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]           loss_q, loss_d;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ST_WAIT_LOCK;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            loss_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= pll_locked_in;
            sync2_q    <= sync1_q;
            lock_cnt_q <= lock_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            loss_q     <= loss_d;
        end
    end

    // sync2_q is the synchronized lock; any sampled low restarts the stability window.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        hold_cnt_d = hold_cnt_q;
        loss_d     = loss_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (!sync2_q) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!sync2_q) begin
                    state_d    = ST_WAIT_LOCK;
                    lock_cnt_d = '0;
                end else if (button_req_in) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!sync2_q) begin
                    state_d    = ST_WAIT_LOCK;
                    lock_cnt_d = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (button_req_in) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_WAIT_LOCK;
                lock_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign soc_reset_out       = (state_q != ST_RUN);
    assign ready_out           = (state_q == ST_RUN);
    assign state_out           = state_q;
    assign lock_loss_count_out = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timing scenarios plus randomized
// lock/button/reset traffic compared against a behavioural model.
module tb_reset_sequencer;

    localparam int LSC  = 8;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       btn = 1'b0;
    logic       soc_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss;

    int total = 0;
    int bad   = 0;

    // Behavioural model: lock history as a 2-deep delay, a run of consecutive
    // stable samples, a countdown of remaining hold cycles, and a loss tally.
    int m_hist[2];
    int m_mode;
    int m_streak;
    int m_left;
    int m_loss;

    reset_sequencer #(.LOCK_STABLE_CYCLES(LSC), .HOLD_CYCLES(HOLD)) dut (
        .clk_in              (clk),
        .reset_in            (rst),
        .pll_locked_in       (lock),
        .button_req_in       (btn),
        .soc_reset_out       (soc_rst),
        .ready_out           (ready),
        .state_out           (state),
        .lock_loss_count_out (loss)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int seen;
        if (rst) begin
            m_hist[0] = 0; m_hist[1] = 0;
            m_mode = 0; m_streak = 0; m_left = 0; m_loss = 0;
            return;
        end
        seen = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = lock ? 1 : 0;
        if (m_mode == 0) begin
            if (seen == 0) m_streak = 0;
            else begin
                m_streak++;
                if (m_streak >= LSC) begin m_mode = 1; m_left = HOLD; end
            end
        end else if (m_mode == 1) begin
            if (seen == 0) begin m_mode = 0; m_streak = 0; end
            else if (btn) m_left = HOLD;
            else begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end else begin
            if (seen == 0) begin
                m_mode = 0; m_streak = 0;
                if (m_loss < 255) m_loss++;
            end else if (btn) begin
                m_mode = 1; m_left = HOLD;
            end
        end
    endtask

    // Advance one rising edge, update the model, and settle before sampling.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int cycles, input logic lk);
        rst = 1'b1; lock = lk; btn = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int exp_state;
        do_reset(5, 1'b1);
        total++;
        if (soc_rst !== 1'b1 || ready !== 1'b0 || state !== 2'd0 || loss !== 8'd0) begin
            bad++;
            $display("FAIL reset_values soc=%0b ready=%0b state=%0d loss=%0d want 1 0 0 0", soc_rst, ready, state, loss);
        end
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp_state = (e < 2 + LSC) ? 0 : (e < 2 + LSC + HOLD) ? 1 : 2;
            total++;
            if (state !== exp_state[1:0] || soc_rst !== (exp_state != 2) || ready !== (exp_state == 2)) begin
                bad++;
                $display("FAIL powerup edge=%0d state=%0d soc=%0b ready=%0b want state=%0d", e, state, soc_rst, ready, exp_state);
            end
        end
    endtask

    task automatic test_late_lock();
        do_reset(3, 1'b0);
        for (int e = 1; e <= 40; e++) begin
            tick();
            total++;
            if (state !== 2'd0 || soc_rst !== 1'b1) begin
                bad++;
                $display("FAIL late_lock_wait edge=%0d state=%0d soc=%0b want 0 1", e, state, soc_rst);
            end
        end
        lock = 1'b1;
        for (int e = 1; e <= 2 + LSC + HOLD; e++) begin
            tick();
            if (e == 2 + LSC + HOLD - 1) begin
                total++;
                if (state === 2'd2) begin bad++; $display("FAIL late_lock_early edge=%0d state=%0d want not 2", e, state); end
            end
        end
        total++;
        if (state !== 2'd2 || ready !== 1'b1) begin
            bad++;
            $display("FAIL late_lock_run state=%0d ready=%0b want 2 1", state, ready);
        end
    endtask

    task automatic test_unstable_lock();
        do_reset(3, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            lock = (e == 6) ? 1'b0 : 1'b1;
            tick();
            // lock sampled low at edge 6 reaches the FSM at edge 8; 8 stable edges follow from edge 9
            total++;
            if (e <= 15 && state !== 2'd0) begin
                bad++; $display("FAIL unstable_early_hold edge=%0d state=%0d want 0", e, state);
            end else if (e >= 16 && state !== 2'd1) begin
                bad++; $display("FAIL unstable_hold edge=%0d state=%0d want 1", e, state);
            end
        end
    endtask

    task automatic reach_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = (ready === 1'b1);
        end
    endtask

    task automatic test_button();
        bit ok;
        int high;
        do_reset(2, 1'b1);
        reach_run(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL button_setup ready=%0b want 1", ready); end
        btn = 1'b1; tick(); btn = 1'b0;
        high = (soc_rst === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && soc_rst === 1'b1; i++) begin
            tick();
            if (soc_rst === 1'b1) high++;
        end
        total++;
        if (high != HOLD) begin bad++; $display("FAIL button_single high=%0d want %0d", high, HOLD); end
        total++;
        if (loss !== 8'd0 || state !== 2'd2) begin
            bad++; $display("FAIL button_after loss=%0d state=%0d want 0 2", loss, state);
        end
        btn = 1'b1; tick(); btn = 1'b0;
        high = 1;
        repeat (10) begin tick(); if (soc_rst === 1'b1) high++; end
        btn = 1'b1; tick(); btn = 1'b0;
        if (soc_rst === 1'b1) high++;
        for (int i = 0; i < 40 && soc_rst === 1'b1; i++) begin
            tick();
            if (soc_rst === 1'b1) high++;
        end
        total++;
        if (high != 27) begin bad++; $display("FAIL button_stretch high=%0d want 27", high); end
    endtask

    task automatic test_lock_loss();
        bit ok;
        do_reset(2, 1'b1);
        reach_run(ok);
        lock = 1'b0;
        tick(); tick();
        btn = 1'b1; tick(); btn = 1'b0;
        total++;
        if (!ok || state !== 2'd0 || loss !== 8'd1) begin
            bad++; $display("FAIL loss_with_button state=%0d loss=%0d want 0 1", state, loss);
        end
        for (int n = 2; n <= 300; n++) begin
            lock = 1'b1;
            reach_run(ok);
            if (!ok) begin
                total++; bad++;
                $display("FAIL loss_rerun_timeout event=%0d state=%0d", n, state);
                break;
            end
            lock = 1'b0;
            repeat (3) tick();
            if (n == 100 || n >= 254) begin
                total++;
                if (loss !== 8'((n > 255) ? 255 : n)) begin
                    bad++; $display("FAIL loss_count event=%0d loss=%0d want %0d", n, loss, (n > 255) ? 255 : n);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        do_reset(2, 1'b1);
        reach_run(ok);
        lock = 1'b0; repeat (3) tick();
        lock = 1'b1;
        for (int i = 0; i < 40 && state !== 2'd1; i++) tick();
        repeat (7) tick();
        total++;
        if (loss !== 8'd1 || state !== 2'd1) begin
            bad++; $display("FAIL midhold_setup loss=%0d state=%0d want 1 1", loss, state);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (state !== 2'd0 || loss !== 8'd0 || soc_rst !== 1'b1) begin
            bad++; $display("FAIL midhold_reset state=%0d loss=%0d soc=%0b want 0 0 1", state, loss, soc_rst);
        end
        for (int e = 1; e <= 2 + LSC + HOLD; e++) begin
            tick();
            if (e == 2 + LSC) begin
                total++;
                if (state !== 2'd1) begin bad++; $display("FAIL midhold_restart_hold state=%0d want 1", state); end
            end
        end
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL midhold_restart_run state=%0d want 2", state); end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset(2, 1'b1);
        for (int c = 0; c < 4000; c++) begin
            lock = ($urandom_range(0, 99) < 94);
            btn  = ($urandom_range(0, 99) < 4);
            rst  = ($urandom_range(0, 999) < 3);
            tick();
            total++;
            if (state !== 2'(m_mode) || soc_rst !== (m_mode != 2) || ready !== (m_mode == 2) || loss !== 8'(m_loss)) begin
                bad++;
                if (errs < 10) $display("FAIL random cyc=%0d state=%0d soc=%0b ready=%0b loss=%0d want state=%0d loss=%0d",
                                        c, state, soc_rst, ready, loss, m_mode, m_loss);
                errs++;
            end
        end
        rst = 1'b0; btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_late_lock();
        test_unstable_lock();
        test_button();
        test_lock_loss();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
